// File: rtl/lsu_atomic_if.sv
// rtl/lsu_atomic_if.sv - data-memory read/write channels between one LSU and the memory controller
interface lsu_atomic_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_atomic.sv
// rtl/lsu_atomic.sv - per-thread load/store unit with atomic fetch-and-add and wait timeout
module lsu_atomic #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic                 decoded_mem_atomic_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_atomic_if.master         mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int         TW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW:0] TIMEOUT_LIM = (TW + 1)'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD_WAIT,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 error_q, error_d;
  logic                 atomic_q, atomic_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [TW:0]          timer_inc;
  logic                 timeout_hit;
  logic [1:0]           n_enables;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    error_d    = error_q;
    atomic_d   = atomic_q;
    timer_d    = timer_q;

    n_enables   = 2'(decoded_mem_read_enable) + 2'(decoded_mem_write_enable)
                + 2'(decoded_mem_atomic_enable);
    timer_inc   = {1'b0, timer_q} + {{TW{1'b0}}, 1'b1};
    // The cycle that would reach the limit aborts unless ready is also present.
    timeout_hit = TIMEOUT_EN && (timer_inc >= TIMEOUT_LIM);

    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (core_state == CORE_REQUEST && n_enables != 2'd0) begin
            state_d = S_REQ;
          end
        end

        S_REQ: begin
          timer_d = '0;
          if (n_enables != 2'd1) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (decoded_mem_write_enable) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rs;
            wr_data_d  = rt;
            state_d    = S_WR_WAIT;
          end else begin
            rd_valid_d = 1'b1;
            rd_addr_d  = rs;
            atomic_d   = decoded_mem_atomic_enable;
            state_d    = S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (mem.mem_read_ready) begin
            out_d      = mem.mem_read_data;
            rd_valid_d = 1'b0;
            if (atomic_q) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = rd_addr_q;
              wr_data_d  = mem.mem_read_data + rt;
              timer_d    = '0;
              state_d    = S_WR_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end else if (timeout_hit) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            error_d    = 1'b1;
            out_d      = '1;
            state_d    = S_DONE;
          end else begin
            timer_d = timer_inc[TW-1:0];
          end
        end

        S_WR_WAIT: begin
          if (mem.mem_write_ready) begin
            wr_valid_d = 1'b0;
            state_d    = S_DONE;
          end else if (timeout_hit) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            error_d    = 1'b1;
            out_d      = '1;
            state_d    = S_DONE;
          end else begin
            timer_d = timer_inc[TW-1:0];
          end
        end

        S_DONE: begin
          if (core_state == CORE_UPDATE) begin
            error_d = 1'b0;
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      error_q    <= 1'b0;
      atomic_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      error_q    <= error_d;
      atomic_q   <= atomic_d;
      timer_q    <= timer_d;
    end
  end

  // Both wait states share the scheduler's WAITING code.
  always_comb begin
    lsu_state = 2'b00;
    case (state_q)
      S_IDLE:    lsu_state = 2'b00;
      S_REQ:     lsu_state = 2'b01;
      S_RD_WAIT: lsu_state = 2'b10;
      S_WR_WAIT: lsu_state = 2'b10;
      S_DONE:    lsu_state = 2'b11;
      default:   lsu_state = 2'b00;
    endcase
  end

  assign mem.mem_read_valid    = rd_valid_q;
  assign mem.mem_read_address  = rd_addr_q;
  assign mem.mem_write_valid   = wr_valid_q;
  assign mem.mem_write_address = wr_addr_q;
  assign mem.mem_write_data    = wr_data_q;
  assign lsu_out               = out_q;
  assign lsu_error             = error_q;

endmodule

// File: tb/tb_lsu_atomic.sv
// tb/tb_lsu_atomic.sv - directed and randomized checks of lsu_atomic against a transaction-level model
module tb_lsu_atomic;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en, wr_en, at_en;
  logic [AB-1:0] rs;
  logic [DB-1:0] rt;
  logic [1:0]    lsu_state;
  logic [DB-1:0] lsu_out;
  logic          lsu_error;

  lsu_atomic_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mbus ();

  lsu_atomic #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .enable                    (enable),
    .core_state                (core_state),
    .decoded_mem_read_enable   (rd_en),
    .decoded_mem_write_enable  (wr_en),
    .decoded_mem_atomic_enable (at_en),
    .rs                        (rs),
    .rt                        (rt),
    .mem                       (mbus),
    .lsu_state                 (lsu_state),
    .lsu_out                   (lsu_out),
    .lsu_error                 (lsu_error)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DB-1:0] mem [256];
  logic [DB-1:0] model_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: ready is given on cycle rcyc/wcyc of valid; beyond TO the op aborts.
  task automatic do_op(input string tag, input bit rd, input bit wr, input bit at,
                       input logic [AB-1:0] a, input logic [DB-1:0] d,
                       input int rcyc, input int wcyc);
    int            n, e_rc, e_wc, e_lat, cyc, rc, wc, st_bad, exp_st;
    logic          e_err;
    bit            commit;
    logic [DB-1:0] e_out, e_wdata, base, wr_data;
    logic [AB-1:0] rd_addr, wr_addr;

    n = int'(rd) + int'(wr) + int'(at);
    base = mem[a];
    e_rc = 0; e_wc = 0; e_err = 1'b0; e_out = model_out; e_wdata = d; commit = 1'b0;
    if (n != 1) begin
      e_err = 1'b1;
    end else begin
      if (rd || at) begin
        if (rcyc > TO) begin e_rc = TO; e_err = 1'b1; e_out = '1; end
        else begin e_rc = rcyc; e_out = base; end
      end
      if (wr || (at && !e_err)) begin
        e_wdata = wr ? d : base + d;
        if (wcyc > TO) begin e_wc = TO; e_err = 1'b1; e_out = '1; end
        else begin e_wc = wcyc; commit = 1'b1; end
      end
    end
    e_lat = 2 + e_rc + e_wc;

    rd_en = rd; wr_en = wr; at_en = at; rs = a; rt = d; core_state = 3'b011;
    cyc = 0; rc = 0; wc = 0; st_bad = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    while (lsu_state != 2'b11 && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1) core_state = 3'b000;
      if (cyc == 2) begin
        rd_en = 1'($urandom); wr_en = 1'($urandom); at_en = 1'($urandom); rs = 8'($urandom);
      end
      exp_st = (cyc == 1) ? 1 : ((cyc < e_lat) ? 2 : 3);
      if (int'(lsu_state) != exp_st) st_bad++;
      if (mbus.mem_read_valid) begin
        rc++;
        rd_addr = mbus.mem_read_address;
        mbus.mem_read_ready = (rc == rcyc);
        mbus.mem_read_data  = (rc == rcyc) ? mem[mbus.mem_read_address] : 8'($urandom);
      end else begin
        mbus.mem_read_ready = 1'($urandom);
        mbus.mem_read_data  = 8'($urandom);
      end
      if (mbus.mem_write_valid) begin
        wc++;
        wr_addr = mbus.mem_write_address;
        wr_data = mbus.mem_write_data;
        mbus.mem_write_ready = (wc == wcyc);
      end else begin
        mbus.mem_write_ready = 1'($urandom);
      end
    end

    chk({tag, ".latency"}, cyc, e_lat);
    chk({tag, ".state_seq_bad"}, st_bad, 0);
    chk({tag, ".rd_cycles"}, rc, e_rc);
    chk({tag, ".wr_cycles"}, wc, e_wc);
    if (e_rc > 0) chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(a));
    if (e_wc > 0) begin
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
      chk({tag, ".wr_data"}, 32'(wr_data), 32'(e_wdata));
    end
    chk({tag, ".out"}, 32'(lsu_out), 32'(e_out));
    chk({tag, ".err"}, 32'(lsu_error), 32'(e_err));
    chk({tag, ".valids_done"}, 32'({mbus.mem_read_valid, mbus.mem_write_valid}), 32'd0);

    step();
    chk({tag, ".done_hold"}, 32'(lsu_state), 32'd3);
    core_state = 3'b110;
    step();
    chk({tag, ".idle"}, 32'(lsu_state), 32'd0);
    chk({tag, ".err_clear"}, 32'(lsu_error), 32'd0);
    chk({tag, ".out_hold"}, 32'(lsu_out), 32'(e_out));
    core_state = 3'b000;
    rd_en = 1'b0; wr_en = 1'b0; at_en = 1'b0;
    mbus.mem_read_ready = 1'b0; mbus.mem_write_ready = 1'b0;
    if (commit) mem[a] = e_wdata;
    model_out = e_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k, rcyc, wcyc;
    logic [2:0]    code;
    logic [AB-1:0] ra;
    logic [DB-1:0] rd_val;

    reset = 1'b1; enable = 1'b1; core_state = 3'b000;
    rd_en = 1'b0; wr_en = 1'b0; at_en = 1'b0; rs = '0; rt = '0;
    mbus.mem_read_ready = 1'b0; mbus.mem_read_data = '0; mbus.mem_write_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    model_out = '0;
    step();
    step();
    chk("reset.state", 32'(lsu_state), 32'd0);
    chk("reset.out", 32'(lsu_out), 32'd0);
    chk("reset.err", 32'(lsu_error), 32'd0);
    chk("reset.valids", 32'({mbus.mem_read_valid, mbus.mem_write_valid}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle.no_request", 32'(lsu_state), 32'd0);

    mem[8'h10] = 8'hA5;
    do_op("ldr", 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 2, 1);
    do_op("str", 1'b0, 1'b1, 1'b0, 8'h20, 8'h3C, 1, 1);
    mem[8'h05] = 8'hFE;
    do_op("atom_wrap", 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 1, 1);
    do_op("ldr_timeout", 1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 99, 1);
    do_op("illegal_rw", 1'b1, 1'b1, 1'b0, 8'h44, 8'h11, 1, 1);
    do_op("atom_rd_edge_wr_to", 1'b0, 1'b0, 1'b1, 8'h60, 8'h10, TO, 99);

    // Reset while a read is outstanding.
    mem[8'h40] = 8'h77;
    rd_en = 1'b1; rs = 8'h40; core_state = 3'b011;
    step();
    core_state = 3'b000;
    step();
    chk("rst_mid.rv_before", 32'(mbus.mem_read_valid), 32'd1);
    reset = 1'b1; mbus.mem_read_ready = 1'b1; mbus.mem_read_data = 8'h77;
    step();
    chk("rst_mid.rv", 32'(mbus.mem_read_valid), 32'd0);
    chk("rst_mid.wv", 32'(mbus.mem_write_valid), 32'd0);
    chk("rst_mid.state", 32'(lsu_state), 32'd0);
    chk("rst_mid.out", 32'(lsu_out), 32'd0);
    reset = 1'b0; rd_en = 1'b0; mbus.mem_read_ready = 1'b0;
    step();
    chk("rst_mid.no_done", 32'(lsu_state), 32'd0);
    model_out = '0;

    // Enable dropped mid write wait; counter must not advance while frozen.
    wr_en = 1'b1; rs = 8'h50; rt = 8'h9A; core_state = 3'b011;
    step();
    core_state = 3'b000;
    step();
    chk("en.wv_start", 32'(mbus.mem_write_valid), 32'd1);
    step();
    enable = 1'b0; mbus.mem_write_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en.frozen_state", 32'(lsu_state), 32'd2);
      chk("en.frozen_wv", 32'(mbus.mem_write_valid), 32'd1);
    end
    chk("en.frozen_data", 32'(mbus.mem_write_data), 32'h9A);
    enable = 1'b1; mbus.mem_write_ready = 1'b0;
    step();
    step();
    chk("en.still_wait", 32'(lsu_state), 32'd2);
    mbus.mem_write_ready = 1'b1;
    step();
    chk("en.done", 32'(lsu_state), 32'd3);
    chk("en.no_error", 32'(lsu_error), 32'd0);
    chk("en.wv_drop", 32'(mbus.mem_write_valid), 32'd0);
    mbus.mem_write_ready = 1'b0; wr_en = 1'b0; core_state = 3'b110;
    step();
    chk("en.idle", 32'(lsu_state), 32'd0);
    core_state = 3'b000;
    mem[8'h50] = 8'h9A;

    for (int t = 0; t < 30; t++) begin
      k    = $urandom_range(0, 7);
      code = (k < 6) ? (3'b001 << (k % 3)) : ((k == 6) ? 3'b110 : 3'b111);
      ra   = 8'($urandom);
      rd_val = 8'($urandom);
      rcyc = $urandom_range(1, TO + 1);
      wcyc = $urandom_range(1, TO + 1);
      do_op($sformatf("rand%0d", t), code[0], code[1], code[2], ra, rd_val, rcyc, wcyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_atomic.md
Name: lsu_atomic

Overview:
- Parametrised next-generation per-thread load-store unit; one instance per thread per core.
- Executes LDR (load), STR (store) and a new ATOM (atomic fetch-and-add: read, add rt, write back) against the data-memory controller over valid/ready channels.
- Adds a wait-timeout with an error flag.
- Exposes the same 2-bit progress encoding the core scheduler already consumes.

Parameters:
ADDR_BITS, 8, width of memory address and of rs
DATA_BITS, 8, width of memory data, rt and lsu_out
TIMEOUT_CYCLES, 0, max cycles spent in one wait state before abort; 0 disables timeout

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
enable  input  1  thread active; when low all state and outputs hold
core_state  input  3  core phase; 3'b011 = REQUEST, 3'b110 = UPDATE
decoded_mem_read_enable  input  1  LDR
decoded_mem_write_enable  input  1  STR
decoded_mem_atomic_enable  input  1  ATOM (fetch-and-add)
rs  input  ADDR_BITS  address operand
rt  input  DATA_BITS  store data / addend
mem_read_valid  output  1  read request
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  read response valid, data on mem_read_data
mem_read_data  input  DATA_BITS  read data
mem_write_valid  output  1  write request
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  write acknowledged
lsu_state  output  2  00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
lsu_out  output  DATA_BITS  loaded value (ATOM: pre-add value)
lsu_error  output  1  op aborted (timeout or illegal decode); valid in DONE

Behaviour:
- Reset: all outputs 0, internal state IDLE, timeout counter 0. Reset mid-operation drops both valids at the next edge; no completion is reported.
- enable low: no transitions, counter frozen, outputs hold.
- Internal FSM: IDLE, REQ, RD_WAIT, WR_WAIT, DONE.
  - lsu_state mapping: IDLE=00, REQ=01, RD_WAIT and WR_WAIT=10, DONE=11.
- IDLE -> REQ when core_state==3'b011 and any decoded enable is high. Otherwise stay in IDLE.
- REQ, exactly one enable high:
  - read or atomic: mem_read_valid<=1, mem_read_address<=rs, go RD_WAIT.
  - write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt, go WR_WAIT.
- REQ, illegal decode (two or more enables high, or none): no memory access; lsu_error<=1, lsu_out unchanged, go DONE.
- RD_WAIT on mem_read_ready (sampled while mem_read_valid=1):
  - Capture mem_read_data into lsu_out and drop mem_read_valid.
  - Read: go DONE.
  - Atomic: mem_write_valid<=1, mem_write_address<=read address, mem_write_data<=(mem_read_data+rt) mod 2^DATA_BITS, go WR_WAIT. lsu_state stays 10 throughout.
- WR_WAIT on mem_write_ready: mem_write_valid<=0, go DONE.
- Ready acceptance: ready may arrive on the first cycle valid is high, giving a minimum of 1 cycle in the wait state. Latency: read REQUEST->DONE min 3 edges; atomic min 4. Ready inputs are ignored outside the matching wait state.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entry to each wait state and increments each enabled cycle without ready.
  - When the count reaches TIMEOUT_CYCLES without ready: drop both valids, lsu_error<=1, lsu_out<=all ones, go DONE.
  - Ready arriving in that same cycle wins and counts as normal completion.
- DONE -> IDLE when core_state==3'b110; lsu_error clears on that transition. DONE holds otherwise.
- Decoded enables are sampled only in REQ; changes in the wait states are ignored.

Test Plan:
- Defaults, LDR rs=8'h10, memory returns 8'hA5 with 2-cycle delay -> read_valid high 2 cycles, addr 8'h10, lsu_out=8'hA5, lsu_state 01->10->11, back to 00 on UPDATE.
- STR rs=8'h20 rt=8'h3C, write_ready on first valid cycle -> write_valid exactly 1 cycle, addr 8'h20, data 8'h3C, DONE.
- ATOM rs=8'h05 rt=8'h03, memory holds 8'hFE -> read of 8'h05 then write of 8'h01 (wrap) to 8'h05, lsu_out=8'hFE, lsu_error=0.
- TIMEOUT_CYCLES=4, LDR with ready never asserted -> valid drops after 4 cycles, lsu_error=1, lsu_out=8'hFF, DONE; UPDATE clears error.
- Read+write enables both high at REQUEST -> no valid ever asserted, lsu_error=1, DONE next edge.
- Reset asserted mid RD_WAIT, then enable toggled low mid WR_WAIT in a second op -> reset: valids 0 next edge, lsu_state 00; enable low: state and write_valid frozen until enable returns.
